// File: rtl/fifo_pkg.sv
// Shared constants for the fifo_flex family: read-mode selectors and depth helper.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int ptr);
    return 1 << ptr;
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Handshake/data bundle between a fifo_flex instance and its producer/consumer.
interface fifo_flex_if #(
  parameter int WORD_SIZE = 10,
  parameter int PTR       = 3
);

  logic                 fifo_wr;
  logic                 fifo_rd;
  logic [WORD_SIZE-1:0] fifo_data_in;
  logic [PTR:0]         full_threshold;
  logic [PTR:0]         empty_threshold;
  logic                 error_clr;

  logic [WORD_SIZE-1:0] fifo_data_out;
  logic                 data_valid;
  logic [PTR:0]         fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 error;

  modport master (
    output fifo_wr, fifo_rd, fifo_data_in, full_threshold, empty_threshold, error_clr,
    input  fifo_data_out, data_valid, fifo_count, fifo_full, fifo_empty,
           almost_full, almost_empty, error
  );

  modport slave (
    input  fifo_wr, fifo_rd, fifo_data_in, full_threshold, empty_threshold, error_clr,
    output fifo_data_out, data_valid, fifo_count, fifo_full, fifo_empty,
           almost_full, almost_empty, error
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WORD_SIZE storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram #(
  parameter int WORD_SIZE = 10,
  parameter int PTR       = 3
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [PTR-1:0]       i_waddr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  input  logic [PTR-1:0]       i_raddr,
  output logic [WORD_SIZE-1:0] o_rdata
);

  logic [WORD_SIZE-1:0] r_mem [2**PTR];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags, sticky error
// and selectable registered / first-word-fall-through read.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WORD_SIZE = 10,
  parameter int PTR       = 3,
  parameter int FWFT      = FIFO_MODE_REG
) (
  input  logic        clk,
  input  logic        reset,
  fifo_flex_if.slave  bus
);

  localparam int           DEPTH   = fifo_depth(PTR);
  localparam logic [PTR:0] W_DEPTH = (PTR+1)'(DEPTH);

  logic [PTR:0]         r_wr_ptr;
  logic [PTR:0]         r_rd_ptr;
  logic [PTR:0]         r_count;
  logic                 r_error;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic [PTR:0]         w_occupancy;
  logic [WORD_SIZE-1:0] w_ram_rdata;

  assign w_full      = (r_count == W_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_rd_acc    = bus.fifo_rd & ~w_empty;
  assign w_wr_acc    = bus.fifo_wr & (~w_full | w_rd_acc);
  assign w_occupancy = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + (PTR+1)'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + (PTR+1)'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + (PTR+1)'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - (PTR+1)'(1);
      // set has priority over clear when both land in the same cycle
      if ((bus.fifo_wr & ~w_wr_acc) | (bus.fifo_rd & ~w_rd_acc)) r_error <= 1'b1;
      else if (bus.error_clr)                                   r_error <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (w_occupancy == r_count);
  end

  fifo_ram #(
    .WORD_SIZE (WORD_SIZE),
    .PTR       (PTR)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc & ~reset),
    .i_waddr (r_wr_ptr[PTR-1:0]),
    .i_wdata (bus.fifo_data_in),
    .i_raddr (r_rd_ptr[PTR-1:0]),
    .o_rdata (w_ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // memory is never reset, so the head word is masked while nothing is stored
      assign bus.fifo_data_out = w_empty ? '0 : w_ram_rdata;
      assign bus.data_valid    = ~w_empty;
    end else begin : g_reg
      logic [WORD_SIZE-1:0] r_dout;
      logic                 r_valid;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_dout <= w_ram_rdata;
        end
      end
      assign bus.fifo_data_out = r_dout;
      assign bus.data_valid    = r_valid;
    end
  endgenerate

  assign bus.fifo_count   = r_count;
  assign bus.fifo_full    = w_full;
  assign bus.fifo_empty   = w_empty;
  assign bus.almost_full  = (r_count >= bus.full_threshold);
  assign bus.almost_empty = (r_count <= bus.empty_threshold);
  assign bus.error        = r_error;

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: a registered-read and an FWFT instance share stimulus
// and are compared against a queue-based occupancy/data model.
module tb_fifo_flex;

  localparam int W     = 10;
  localparam int P     = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_flex_if #(.WORD_SIZE(W), .PTR(P)) b0 ();
  fifo_flex_if #(.WORD_SIZE(W), .PTR(P)) b1 ();

  fifo_flex #(.WORD_SIZE(W), .PTR(P), .FWFT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  fifo_flex #(.WORD_SIZE(W), .PTR(P), .FWFT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  bit           merr = 1'b0;
  bit           exp_valid = 1'b0;
  int           fth = DEPTH;
  int           eth = 0;
  bit           chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [W-1:0] din, input bit clr);
    b0.fifo_wr = wr; b0.fifo_rd = rd; b0.fifo_data_in = din; b0.error_clr = clr;
    b1.fifo_wr = wr; b1.fifo_rd = rd; b1.fifo_data_in = din; b1.error_clr = clr;
  endtask

  task automatic set_th(input int f, input int e);
    fth = f; eth = e;
    b0.full_threshold = 4'(f); b0.empty_threshold = 4'(e);
    b1.full_threshold = 4'(f); b1.empty_threshold = 4'(e);
  endtask

  // one clock of stimulus; expected read data enters the scoreboard when the read is issued
  task automatic step(input bit wr, input bit rd, input logic [W-1:0] din, input bit clr);
    bit ra, wa;
    drive(wr, rd, din, clr);
    ra = rd && (mq.size() > 0);
    wa = wr && ((mq.size() < DEPTH) || ra);
    if (ra) sb.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(din);
    if ((wr && !wa) || (rd && !ra)) merr = 1'b1;
    else if (clr)                   merr = 1'b0;
    exp_valid = ra;
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 10'h3AA, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    mq.delete();
    merr = 1'b0;
    exp_valid = 1'b0;
    check("rst_dout0", 32'(b0.fifo_data_out), 32'h0);
    check("rst_dout1", 32'(b1.fifo_data_out), 32'h0);
  endtask

  // flag / count checker for both instances
  always @(negedge clk) begin
    if (chk_en) begin
      check("count0", 32'(b0.fifo_count), 32'(mq.size()));
      check("count1", 32'(b1.fifo_count), 32'(mq.size()));
      check("full0", 32'(b0.fifo_full), 32'(mq.size() == DEPTH));
      check("full1", 32'(b1.fifo_full), 32'(mq.size() == DEPTH));
      check("empty0", 32'(b0.fifo_empty), 32'(mq.size() == 0));
      check("empty1", 32'(b1.fifo_empty), 32'(mq.size() == 0));
      check("afull0", 32'(b0.almost_full), 32'(mq.size() >= fth));
      check("afull1", 32'(b1.almost_full), 32'(mq.size() >= fth));
      check("aempty0", 32'(b0.almost_empty), 32'(mq.size() <= eth));
      check("aempty1", 32'(b1.almost_empty), 32'(mq.size() <= eth));
      check("error0", 32'(b0.error), 32'(merr));
      check("error1", 32'(b1.error), 32'(merr));
      check("valid0", 32'(b0.data_valid), 32'(exp_valid));
      check("valid1", 32'(b1.data_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("fwft_head", 32'(b1.fifo_data_out), 32'(mq[0]));
    end
  end

  // registered-read monitor: every valid word must match the oldest expected read
  always @(negedge clk) begin
    if (chk_en && b0.data_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 32'(b0.fifo_data_out), 32'hFFFF_FFFF);
      else                check("rd_data", 32'(b0.fifo_data_out), 32'(sb.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0);
    set_th(DEPTH, 0);
    @(posedge clk);
    #1;
    do_reset();
    chk_en = 1'b1;

    // fill / drain
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i), 1'b0);
    check("fill_full", 32'(b0.fifo_full), 32'h1);
    check("fill_count", 32'(b0.fifo_count), 32'h8);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("drain_empty", 32'(b0.fifo_empty), 32'h1);

    // overflow, then underflow with simultaneous clear, then clear alone
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i), 1'b0);
    step(1'b1, 1'b0, 10'h2AA, 1'b0);
    check("ovf_error", 32'(b0.error), 32'h1);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1);
    check("unf_set_wins", 32'(b0.error), 32'h1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("err_cleared", 32'(b0.error), 32'h0);

    // simultaneous read/write at full
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i), 1'b0);
    step(1'b1, 1'b1, 10'h3FF, 1'b0);
    check("rw_full_count", 32'(b0.fifo_count), 32'h8);
    check("rw_full_dout", 32'(b0.fifo_data_out), 32'h001);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("rw_full_last", 32'(b0.fifo_data_out), 32'h3FF);

    // thresholds
    set_th(6, 2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);

    // wrap-around with occupancy between 3 and 5
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 10'($urandom_range(0, 1023)), 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);
    end

    // randomized traffic: write-heavy then read-heavy phases, occasional reset
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      pw = (i < 200) ? 70 : 35;
      pr = (i < 200) ? 35 : 70;
      if (i % 37 == 0) set_th($urandom_range(0, DEPTH), $urandom_range(0, DEPTH));
      if ($urandom_range(0, 99) < 1) do_reset();
      else step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                10'($urandom_range(0, 1023)), $urandom_range(0, 99) < 10);
    end
    step(1'b0, 1'b0, '0, 1'b1);

    // FWFT: word into empty shows without a read
    do_reset();
    set_th(0, 0);
    step(1'b1, 1'b0, 10'h155, 1'b0);
    check("fwft_dout", 32'(b1.fifo_data_out), 32'h155);
    check("fwft_valid", 32'(b1.data_valid), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0);

    // mid-stream reset drops stored words
    step(1'b1, 1'b0, 10'h011, 1'b0);
    step(1'b1, 1'b0, 10'h022, 1'b0);
    do_reset();
    check("mrst_count", 32'(b0.fifo_count), 32'h0);
    check("mrst_valid1", 32'(b1.data_valid), 32'h0);
    step(1'b1, 1'b0, 10'h0AB, 1'b0);
    check("mrst_new_fwft", 32'(b1.fifo_data_out), 32'h0AB);
    step(1'b0, 1'b1, '0, 1'b0);
    check("mrst_new_reg", 32'(b0.fifo_data_out), 32'h0AB);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised second-generation synchronous FIFO for the packet datapath. Words carry `[WORD_SIZE-1:WORD_SIZE-2]` destination and the remaining data bits. Depth, width, programmable thresholds and read mode are all parametrised. Adds an occupancy count, a read-valid strobe, a sticky clearable error, simultaneous read/write at full, and an optional first-word-fall-through (FWFT) mode. It sits between the packet source and the destination demux, and is instanced per output channel.

## Interface

Parameters:
- `WORD_SIZE`, 10, word width in bits (≥ 3).
- `PTR`, 3, address bits; depth `DEPTH = 2**PTR`.
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_wr`  in  1  write request.
- `fifo_rd`  in  1  read request (acknowledge in FWFT mode).
- `fifo_data_in`  in  WORD_SIZE  write data.
- `full_threshold`  in  PTR+1  almost-full level, 0..DEPTH.
- `empty_threshold`  in  PTR+1  almost-empty level, 0..DEPTH.
- `error_clr`  in  1  clears sticky `error`.
- `fifo_data_out`  out  WORD_SIZE  read data.
- `data_valid`  out  1  `fifo_data_out` holds a valid word.
- `fifo_count`  out  PTR+1  occupancy, 0..DEPTH.
- `fifo_full`  out  1  `fifo_count == DEPTH`.
- `fifo_empty`  out  1  `fifo_count == 0`.
- `almost_full`  out  1  `fifo_count >= full_threshold`.
- `almost_empty`  out  1  `fifo_count <= empty_threshold`.
- `error`  out  1  sticky overflow/underflow flag.

## Operation

- Pointers `wr_ptr` and `rd_ptr` are PTR+1 bits; the MSB is the wrap bit, and the low PTR bits address memory. Pointers wrap naturally at 2·DEPTH.
- `rd_acc = fifo_rd & ~fifo_empty`.
- `wr_acc = fifo_wr & (~fifo_full | rd_acc)`. At full, a simultaneous read and write are both accepted and the count is unchanged.
- At empty, a simultaneous read and write accepts only the write. The read is rejected and counts as underflow.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither.
- All flags decode combinationally from the registered `fifo_count` and the threshold inputs. Threshold changes take effect immediately.
- `error` is set on any cycle with `fifo_wr & ~wr_acc` (overflow) or `fifo_rd & ~rd_acc` (underflow).
  - `error` holds until `error_clr`.
  - If set and clear occur in the same cycle, set wins.
- Rejected operations do not move pointers and do not change the count or memory.
- Memory contents are not reset.

## Timing

- Reset values:
  - pointers 0, `fifo_count` 0, `fifo_empty` 1, `fifo_full` 0;
  - `almost_empty` 1; `almost_full` = (`full_threshold == 0`);
  - `fifo_data_out` 0, `data_valid` 0, `error` 0.
- Reset takes priority over every input in the same cycle. Reset asserted mid-stream drops all stored words; the first post-reset write lands at address 0.
- Write: a word accepted at edge N is readable from cycle N+1. The count increments at edge N.
- `FWFT = 0`:
  - A read accepted in cycle N registers `mem[rd_ptr]` into `fifo_data_out` at edge N.
  - `data_valid` is high for exactly cycle N+1.
  - Between reads, `fifo_data_out` holds its last value.
  - Back-to-back reads give one word per cycle.
- `FWFT = 1`:
  - `fifo_data_out = mem[rd_ptr]` and `data_valid = ~fifo_empty`, with zero read latency.
  - `fifo_rd` pops the displayed word at the edge.
  - A word written into an empty FIFO appears in cycle N+1.

## Structure

- Shared package `fifo_pkg`:
  - depth/width helper constants (`DEPTH` from `PTR`);
  - read-mode constants `FIFO_MODE_REG = 0`, `FIFO_MODE_FWFT = 1`.
- Sub-module `fifo_ram`: a DEPTH×WORD_SIZE dual-port array with a synchronous write port and an asynchronous read address.
  - `FWFT = 0` registers `fifo_ram` output in the top level.
- Pointer, count, flag and error logic live in `fifo_flex`.

## Test plan

(Default parameters, DEPTH = 8, unless noted.)
- **Fill/drain.**
  - Stimulus: reset, then write 0x001..0x008 on 8 consecutive cycles, then read 8 cycles.
  - Required: `fifo_full` = 1 and `fifo_count` = 8 after the 8th write.
  - Required: reads return 0x001..0x008 in order, with `data_valid` high one cycle after each `fifo_rd`.
  - Required: finally `fifo_empty` = 1 and `error` = 0.
- **Overflow/underflow and error clear.**
  - Stimulus: write while full.
  - Required: count stays 8, memory unchanged, `error` = 1 next cycle.
  - Stimulus: `error_clr` together with a read on empty.
  - Required: `error` stays 1. A later `error_clr` alone clears it.
- **Simultaneous read/write at full.**
  - Stimulus: FIFO full with 0x001..0x008; `fifo_wr` with 0x3FF plus `fifo_rd`.
  - Required: output 0x001, count stays 8, `error` 0.
  - Required: after 7 more reads, the 8th read returns 0x3FF.
- **Thresholds.**
  - Stimulus: `full_threshold` = 6, `empty_threshold` = 2; step the count 0→8→0.
  - Required: `almost_empty` high for counts 0..2.
  - Required: `almost_full` high for counts 6..8, changing in the same cycle as the count.
- **Wrap-around.**
  - Stimulus: 20 interleaved write/read pairs with count oscillating between 3 and 5.
  - Required: data order preserved across the pointer wrap; no false full/empty.
- **FWFT and mid-stream reset.**
  - Stimulus: `FWFT` = 1, write 0x155 into empty.
  - Required: `fifo_data_out` = 0x155 and `data_valid` = 1 in the next cycle, with no `fifo_rd`.
  - Stimulus: reset with 3 words stored.
  - Required: count 0, `data_valid` 0 next cycle; the next write/read returns the new word.
